// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte requesters, the UART transmitter and uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic                 o_Gap_Timeout;

  modport master (
    output i_Req_Valid, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_Grant, o_TX_DV, o_TX_Byte, o_Gap_Timeout
  );

  modport slave (
    input  i_Req_Valid, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_Grant, o_TX_DV, o_TX_Byte, o_Gap_Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte sources,
// locking ownership from a requester's first byte until its flagged last byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 4096
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  uart_tx_arbiter_if.slave  io_bus
);
  // state        | meaning
  // ST_IDLE      | unowned; pick next valid requester once the transmitter is idle
  // ST_ISSUE     | owner locked; waiting for its next byte (gap counter running)
  // ST_WAIT_DONE | one byte in flight; waiting for the transmitter's done pulse
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_tx_dv;
  logic [7:0]         r_tx_byte;
  logic               r_last;
  logic [GW-1:0]      r_gap;
  logic               r_timeout;

  logic               w_found;
  logic [PW-1:0]      w_sel;
  logic [PW:0]        w_sum;
  logic [PW-1:0]      w_idx;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic [NUM_REQ-1:0] w_own_onehot;
  logic [PW-1:0]      w_next_ptr;

  // Search ptr, ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && io_bus.i_Req_Valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_sel_onehot = NUM_REQ'(1) << w_sel;
  assign w_own_onehot = NUM_REQ'(1) << r_owner;
  assign w_next_ptr   = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_grant   <= '0;
      r_ready   <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= '0;
      r_last    <= 1'b0;
      r_gap     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tx_dv   <= 1'b0;
      r_ready   <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !io_bus.i_TX_Active) begin
            r_owner <= w_sel;
            r_grant <= w_sel_onehot;
            r_gap   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (io_bus.i_Req_Valid[r_owner]) begin
            r_tx_byte <= io_bus.i_Req_Byte[8*r_owner +: 8];
            r_tx_dv   <= 1'b1;
            r_ready   <= w_own_onehot;
            r_last    <= io_bus.i_Req_Last[r_owner];
            r_gap     <= '0;
            r_state   <= ST_WAIT_DONE;
          end else if ((GAP_TIMEOUT != 0) && (r_gap == GAP_MAX)) begin
            r_timeout <= 1'b1;
            r_grant   <= '0;
            r_ptr     <= w_next_ptr;
            r_state   <= ST_IDLE;
          end else if (r_gap != GAP_MAX) begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (io_bus.i_TX_Done) begin
            if (r_last) begin
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= ST_IDLE;
            end else begin
              r_gap   <= '0;
              r_state <= ST_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.o_Grant       = r_grant;
  assign io_bus.o_Req_Ready   = r_ready;
  assign io_bus.o_TX_DV       = r_tx_dv;
  assign io_bus.o_TX_Byte     = r_tx_byte;
  assign io_bus.o_Gap_Timeout = r_timeout;

endmodule
